// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------+
// | alu_pkg : opcodes, flag bit positions and FSM states for alu_seq     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_ADD = 4'h1,
      OP_SUB = 4'h2,
      OP_ADC = 4'h3,
      OP_SBC = 4'h4,
      OP_CMP = 4'h5,
      OP_OR  = 4'h6,
      OP_AND = 4'h7,
      OP_XOR = 4'h8,
      OP_SHL = 4'h9,
      OP_SHR = 4'hA,
      OP_ASR = 4'hB,
      OP_MUL = 4'hC
   } opcode_e;

   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// +----------------------------------------------------------------------+
// | alu_mul_seq : WIDTH-iteration unsigned shift-add multiplier          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [2*WIDTH-1:0] product_o
);

   localparam int CW = $clog2(WIDTH);

   logic               busy_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_prod_d;

   // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
   always_comb begin
      w_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      w_prod_d = {w_sum, prod_q[WIDTH-1:1]};
   end

   assign busy_o    = busy_q;
   assign done_o    = busy_q && (cnt_q == CW'(WIDTH - 1));
   assign product_o = w_prod_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
      end else if (start_i && !busy_q) begin
         busy_q  <= 1'b1;
         cnt_q   <= '0;
         mcand_q <= a_i;
         prod_q  <= {{WIDTH{1'b0}}, b_i};
      end else if (busy_q) begin
         prod_q <= w_prod_d;
         cnt_q  <= cnt_q + CW'(1);
         if (done_o) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// +----------------------------------------------------------------------+
// | alu_seq : registered ALU with status flags and sequential multiplier |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       flags,
   output logic             op_err
);

   localparam int SW = $clog2(WIDTH);
   localparam int M  = WIDTH - 1;

   state_e             state_q;
   logic [WIDTH-1:0]   result_q, result_hi_q;
   logic [3:0]         flags_q;
   logic               out_valid_q, op_err_q;

   logic               w_accept, w_legal, w_wr, w_setf, w_c, w_v, w_cin;
   logic [SW-1:0]      w_amt;
   logic [WIDTH:0]     w_add, w_sub, w_shl, w_shr, w_asr;
   logic [WIDTH-1:0]   w_val;
   logic [3:0]         w_flags;
   logic               w_mul_busy, w_mul_done;
   logic [2*WIDTH-1:0] w_prod;

   assign in_ready  = (state_q == IDLE);
   assign w_accept  = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign flags     = flags_q;
   assign op_err    = op_err_q;

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (w_accept && (opcode == OP_MUL)),
      .a_i       (operand_a),
      .b_i       (operand_b),
      .busy_o    (w_mul_busy),
      .done_o    (w_mul_done),
      .product_o (w_prod)
   );

   // Shifts run one bit wider so the last bit shifted out lands in bit WIDTH or bit 0.
   always_comb begin
      w_amt   = operand_b[SW-1:0];
      w_cin   = (opcode == OP_ADC || opcode == OP_SBC) ? flags_q[FLAG_C] : 1'b0;
      w_add   = {1'b0, operand_a} + {1'b0, operand_b} + {{WIDTH{1'b0}}, w_cin};
      w_sub   = {1'b0, operand_a} - {1'b0, operand_b} - {{WIDTH{1'b0}}, w_cin};
      w_shl   = {1'b0, operand_a} << w_amt;
      w_shr   = {operand_a, 1'b0} >> w_amt;
      w_asr   = $signed({operand_a, 1'b0}) >>> w_amt;
      w_val   = result_q;
      w_legal = 1'b1;
      w_wr    = 1'b1;
      w_setf  = 1'b1;
      w_c     = 1'b0;
      w_v     = 1'b0;
      case (opcode)
         OP_NOP: begin w_wr = 1'b0; w_setf = 1'b0; end
         OP_ADD, OP_ADC: begin
            w_val = w_add[M:0];
            w_c   = w_add[WIDTH];
            w_v   = (operand_a[M] == operand_b[M]) && (w_add[M] != operand_a[M]);
         end
         OP_SUB, OP_SBC, OP_CMP: begin
            w_val = w_sub[M:0];
            w_wr  = (opcode != OP_CMP);
            w_c   = w_sub[WIDTH];
            w_v   = (operand_a[M] != operand_b[M]) && (w_sub[M] != operand_a[M]);
         end
         OP_OR:  w_val = operand_a | operand_b;
         OP_AND: w_val = operand_a & operand_b;
         OP_XOR: w_val = operand_a ^ operand_b;
         OP_SHL: begin w_val = w_shl[M:0];     w_c = w_shl[WIDTH]; end
         OP_SHR: begin w_val = w_shr[WIDTH:1]; w_c = w_shr[0];     end
         OP_ASR: begin w_val = w_asr[WIDTH:1]; w_c = w_asr[0];     end
         OP_MUL: begin w_wr = 1'b0; w_setf = 1'b0; end
         default: begin w_legal = 1'b0; w_wr = 1'b0; w_setf = 1'b0; end
      endcase
      w_flags = flags_q;
      if (w_setf) begin
         w_flags[FLAG_Z] = (w_val == '0);
         w_flags[FLAG_C] = w_c;
         w_flags[FLAG_N] = w_val[M];
         w_flags[FLAG_V] = w_v;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         result_q    <= '0;
         result_hi_q <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
         op_err_q    <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (w_accept) begin
                  if (opcode == OP_MUL) begin
                     state_q  <= MUL;
                     op_err_q <= 1'b0;
                  end else if (w_legal) begin
                     out_valid_q <= 1'b1;
                     op_err_q    <= 1'b0;
                     result_hi_q <= '0;
                     flags_q     <= w_flags;
                     if (w_wr) begin
                        result_q <= w_val;
                     end
                  end else begin
                     op_err_q <= 1'b1;
                  end
               end
            end
            MUL: begin
               if (w_mul_busy && w_mul_done) begin
                  state_q         <= IDLE;
                  out_valid_q     <= 1'b1;
                  result_q        <= w_prod[M:0];
                  result_hi_q     <= w_prod[2*WIDTH-1:WIDTH];
                  flags_q         <= '0;
                  flags_q[FLAG_Z] <= (w_prod == '0);
                  flags_q[FLAG_C] <= (w_prod[2*WIDTH-1:WIDTH] != '0);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// +----------------------------------------------------------------------+
// | tb_alu_seq : directed-vector bench for alu_seq at WIDTH = 8          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_alu_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] opcode;
   logic [7:0] operand_a, operand_b;
   logic       out_valid;
   logic [7:0] result, result_hi;
   logic [3:0] flags;
   logic       op_err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .out_valid (out_valid),
      .result    (result),
      .result_hi (result_hi),
      .flags     (flags),
      .op_err    (op_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one op at a falling edge; returns at the next falling edge with its outputs visible.
   task automatic apply(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      in_valid  = 1'b1;
      opcode    = op;
      operand_a = a;
      operand_b = b;
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   // flags nibble is {V,N,C,Z}
   initial begin
      int cyc, low_cnt, ov_cyc, pulses;
      rst_n = 1'b0; in_valid = 1'b0; opcode = 4'h0; operand_a = 8'h00; operand_b = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_result", {24'd0, result}, 32'h00);
      chk("rst_hi", {24'd0, result_hi}, 32'h00);
      chk("rst_flags", {28'd0, flags}, 32'h0);
      chk("rst_valid_err", {30'd0, out_valid, op_err}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      apply(4'h1, 8'h7F, 8'h01);
      chk("add_res", {24'd0, result}, 32'h80);
      chk("add_flags", {28'd0, flags}, 32'hC);
      chk("add_valid", {31'd0, out_valid}, 32'd1);

      apply(4'h2, 8'h00, 8'h01);
      chk("sub_res", {24'd0, result}, 32'hFF);
      chk("sub_flags", {28'd0, flags}, 32'h6);
      apply(4'h4, 8'h05, 8'h01);
      chk("sbc_res", {24'd0, result}, 32'h03);
      chk("sbc_flags", {28'd0, flags}, 32'h0);

      apply(4'h1, 8'hFF, 8'h01);
      chk("addc_res", {24'd0, result}, 32'h00);
      chk("addc_flags", {28'd0, flags}, 32'h3);
      apply(4'h3, 8'h00, 8'h00);
      chk("adc_res", {24'd0, result}, 32'h01);
      chk("adc_flags", {28'd0, flags}, 32'h0);

      apply(4'h9, 8'h81, 8'h01);
      chk("shl_res", {24'd0, result}, 32'h02);
      chk("shl_flags", {28'd0, flags}, 32'h2);
      apply(4'hB, 8'h80, 8'h03);
      chk("asr_res", {24'd0, result}, 32'hF0);
      chk("asr_flags", {28'd0, flags}, 32'h4);
      apply(4'hA, 8'h5A, 8'h08);
      chk("shr0_res", {24'd0, result}, 32'h5A);
      chk("shr0_flags", {28'd0, flags}, 32'h0);
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);
      idle();
      chk("valid_drop", {31'd0, out_valid}, 32'd0);

      apply(4'hC, 8'hFF, 8'hFF);
      opcode = 4'h1; operand_a = 8'h01; operand_b = 8'h01;
      cyc = 1; low_cnt = 0; ov_cyc = 0;
      while (cyc <= 20 && ov_cyc == 0) begin
         if (!in_ready) low_cnt++;
         if (out_valid) begin
            ov_cyc = cyc;
         end else begin
            in_valid = !in_ready && cyc[0];
            @(negedge clk);
            cyc++;
         end
      end
      in_valid = 1'b0;
      chk("mul_ready_low", low_cnt, 32'd8);
      chk("mul_latency", ov_cyc, 32'd9);
      chk("mul_lo", {24'd0, result}, 32'h01);
      chk("mul_hi", {24'd0, result_hi}, 32'hFE);
      chk("mul_flags", {28'd0, flags}, 32'h2);
      @(negedge clk);
      chk("mul_valid_drop", {31'd0, out_valid}, 32'd0);
      apply(4'h1, 8'h01, 8'h01);
      chk("post_mul_res", {24'd0, result}, 32'h02);
      chk("post_mul_hi", {24'd0, result_hi}, 32'h00);

      apply(4'hC, 8'h0F, 8'h0F);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_result", {24'd0, result}, 32'h00);
      chk("abort_flags_hi", {20'd0, flags, result_hi}, 32'h0);
      chk("abort_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      chk("abort_no_valid", pulses, 32'd0);

      apply(4'h1, 8'h7F, 8'h01);
      apply(4'hF, 8'h12, 8'h34);
      chk("ill_err", {31'd0, op_err}, 32'd1);
      chk("ill_res", {24'd0, result}, 32'h80);
      chk("ill_flags", {28'd0, flags}, 32'hC);
      apply(4'h6, 8'h0F, 8'h30);
      chk("or_err", {31'd0, op_err}, 32'd0);
      chk("or_res", {24'd0, result}, 32'h3F);
      chk("or_flags", {28'd0, flags}, 32'h0);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
